// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the register-file write-back arbiter.
//   REG_ADDR_W / DATA_W : register address and data widths
//   REG_ZERO            : the hard-wired zero register, never written
//   wb_req_t            : one write request {valid, addr, data}
//   arb_state_e         : arbiter priority state
//   is_writable()       : true for any register that may legally be written
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // ARB_NORMAL: the pipeline wins every conflict.
  // ARB_FIFO_PRIO: the FIFO head was starved, so it wins until it issues.
  typedef enum logic {
    ARB_NORMAL    = 1'b0,
    ARB_FIFO_PRIO = 1'b1
  } arb_state_e;

  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundles every bus-side signal of the write-back arbiter.
//   pipe_*        : in-order pipeline WB request and the stall back to it
//   ls_*          : long-latency (mult/div) valid/ready result channel
//   rf_*          : registered register-file write port
//   chk_addr1/2   : decode read addresses, pend1/2 the queued-write flags
//   fifo_count    : current long-latency FIFO occupancy
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding core (or a testbench) driving the arbiter
// ---------------------------------------------------------------------------
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0]     pipe_data;
  logic                  pipe_stall;

  logic                  ls_valid;
  logic                  ls_ready;
  logic [REG_ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0]     ls_data;

  logic                  rf_wr;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_data;

  logic [REG_ADDR_W-1:0] chk_addr1;
  logic [REG_ADDR_W-1:0] chk_addr2;
  logic                  pend1;
  logic                  pend2;

  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    output pipe_stall,
    input  ls_valid, ls_addr, ls_data,
    output ls_ready,
    output rf_wr, rf_addr, rf_data,
    input  chk_addr1, chk_addr2,
    output pend1, pend2,
    output fifo_count
  );

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    input  pipe_stall,
    output ls_valid, ls_addr, ls_data,
    input  ls_ready,
    input  rf_wr, rf_addr, rf_data,
    output chk_addr1, chk_addr2,
    input  pend1, pend2,
    input  fifo_count
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry circular queue of pending long-latency register writes.
// Each slot carries its own valid bit so a newer pipeline write can kill
// older queued writes to the same register without reshuffling the queue.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_addr/data  : enqueue one entry at the tail
//   pop                   : retire the head slot (live or killed)
//   kill, kill_addr       : invalidate every live entry with that address
//   chk_addr1/2, match1/2 : "live entry for this register" lookups
//   head                  : head slot; head.valid is 0 if empty or killed
//   count                 : occupancy, including killed slots not yet popped
// ---------------------------------------------------------------------------
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output wb_req_t               head,
  output logic [CNT_W-1:0]      count,
  output logic                  match1,
  output logic                  match2
);

  logic [DEPTH-1:0]      ent_valid;
  logic [REG_ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0]     ent_data [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  // Storage update. Kill is applied first so that an entry pushed in the
  // same cycle as a matching pipeline write survives: the long-latency
  // value is treated as the newer one. A popped slot has its valid bit
  // cleared so the valid vector alone describes the live entries. Push and
  // pop never hit the same slot because the arbiter only pushes when not
  // full and only pops when not empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_addr[i] == kill_addr) begin
            ent_valid[i] <= 1'b0;
          end
        end
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= push_addr;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending-write lookup for decode; register zero is never pending.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == chk_addr1)) match1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i] == chk_addr2)) match2 = 1'b1;
    end
    match1 = match1 && is_writable(chk_addr1);
    match2 = match2 && is_writable(chk_addr2);
  end

  assign head.valid = (count != '0) && ent_valid[rd_ptr];
  assign head.addr  = ent_addr[rd_ptr];
  assign head.data  = ent_data[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Sole driver of the register-file write port. Chooses each cycle between
// the in-order pipeline WB stage (normally preferred) and the head of a
// small FIFO of long-latency results, and stalls the pipeline when the FIFO
// head has waited STARVE_MAX consecutive cycles.
// Parameters:
//   DEPTH      : FIFO entries (power of two, at least 2)
//   STARVE_MAX : head wait cycles before the pipeline is stalled
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : wb_arbiter_if.slave (pipe_*, ls_*, rf_*, chk/pend, count)
// Build option:
//   WB_LS_BYPASS_EN : when defined, a long-latency beat accepted while the
//   FIFO is empty and the pipeline is not writing goes straight to rf_*.
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  arb_state_e       state;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_next;

  wb_req_t          head;
  wb_req_t          sel_req;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             ls_ready;
  logic             ls_fire;
  logic             pipe_sel;
  logic             fifo_sel;
  logic             byp_sel;
  logic             pop;
  logic             push;
  logic             pend1;
  logic             pend2;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.ls_addr),
    .push_data (bus.ls_data),
    .pop       (pop),
    .kill      (pipe_sel),
    .kill_addr (bus.pipe_addr),
    .chk_addr1 (bus.chk_addr1),
    .chk_addr2 (bus.chk_addr2),
    .head      (head),
    .count     (count),
    .match1    (pend1),
    .match2    (pend2)
  );

  // ls_ready depends only on registered occupancy (and reset), so there is
  // no path from ls_valid; a pop in the full state cannot raise it early.
  assign ls_ready   = !reset && (count < FULL_CNT);
  assign fifo_empty = (count == '0);
  assign ls_fire    = bus.ls_valid && ls_ready;

  // Write selection. A killed head is dropped whatever else is happening,
  // so pop covers both an issued head and a silent discard.
  always_comb begin
    pipe_sel = (state == ARB_NORMAL) && bus.pipe_valid && is_writable(bus.pipe_addr);
    fifo_sel = !pipe_sel && head.valid;
    pop      = fifo_sel || (!fifo_empty && !head.valid);
`ifdef WB_LS_BYPASS_EN
    byp_sel  = ls_fire && is_writable(bus.ls_addr) && fifo_empty && !pipe_sel;
`else
    byp_sel  = 1'b0;
`endif
    push     = ls_fire && is_writable(bus.ls_addr) && !byp_sel;

    sel_req  = '0;
    if (pipe_sel) begin
      sel_req.valid = 1'b1;
      sel_req.addr  = bus.pipe_addr;
      sel_req.data  = bus.pipe_data;
    end else if (fifo_sel) begin
      sel_req = head;
    end else if (byp_sel) begin
      sel_req.valid = 1'b1;
      sel_req.addr  = bus.ls_addr;
      sel_req.data  = bus.ls_data;
    end
  end

  // Starvation counter: counts cycles a non-empty FIFO goes without a pop,
  // saturating at the limit.
  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || pop) begin
      starve_next = '0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  // Priority state: enter FIFO priority the cycle the counter reaches the
  // limit, leave it as soon as one live FIFO entry has been issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_next;
      case (state)
        ARB_NORMAL:    if (starve_next == STARVE_LIM) state <= ARB_FIFO_PRIO;
        ARB_FIFO_PRIO: if (fifo_sel) state <= ARB_NORMAL;
      endcase
    end
  end

  // Registered write port: a selected write shows on rf_* for exactly one
  // cycle; address and data simply hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rf_wr   <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      bus.rf_wr <= sel_req.valid;
      if (sel_req.valid) begin
        bus.rf_addr <= sel_req.addr;
        bus.rf_data <= sel_req.data;
      end
    end
  end

  assign bus.pipe_stall = (state == ARB_FIFO_PRIO);
  assign bus.ls_ready   = ls_ready;
  assign bus.pend1      = pend1;
  assign bus.pend2      = pend2;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. A queue-based reference model tracks
// the pending long-latency writes, the starvation wait and the stall flag,
// and predicts the registered rf_* write for every clock.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          alive;
  } ent_t;

  ent_t        mq[$];
  bit          m_stall;
  int          m_wait;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  // Model: is a live queued write to register a pending?
  function automatic bit m_pend(input logic [4:0] a);
    foreach (mq[i]) if (mq[i].alive && mq[i].addr == a && a != 5'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall = 1'b0;
    m_wait  = 0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // Model: apply one clock of the arbitration rules to the current inputs.
  task automatic model_step();
    int   sz;
    bit   fire, issue_pipe, popped, from_fifo;
    ent_t e;
    sz         = mq.size();
    fire       = bus.ls_valid && (sz < DEPTH);
    issue_pipe = !m_stall && bus.pipe_valid && (bus.pipe_addr != 5'd0);
    popped     = 1'b0;
    from_fifo  = 1'b0;
    m_wr       = 1'b0;
    if (sz > 0) begin
      if (!mq[0].alive) begin
        void'(mq.pop_front());
        popped = 1'b1;
      end else if (!issue_pipe) begin
        m_wr = 1'b1; m_addr = mq[0].addr; m_data = mq[0].data;
        void'(mq.pop_front());
        popped = 1'b1; from_fifo = 1'b1;
      end
    end
    if (issue_pipe) begin
      m_wr = 1'b1; m_addr = bus.pipe_addr; m_data = bus.pipe_data;
      foreach (mq[i]) if (mq[i].addr == bus.pipe_addr) mq[i].alive = 1'b0;
    end
    if (fire && bus.ls_addr != 5'd0) begin
      e.addr = bus.ls_addr; e.data = bus.ls_data; e.alive = 1'b1;
`ifdef WB_LS_BYPASS_EN
      if (sz == 0 && !issue_pipe) begin
        m_wr = 1'b1; m_addr = e.addr; m_data = e.data;
      end else begin
        mq.push_back(e);
      end
`else
      mq.push_back(e);
`endif
    end
    if (sz == 0 || popped) m_wait = 0;
    else if (m_wait < STARVE_MAX) m_wait++;
    if (m_stall && from_fifo) m_stall = 1'b0;
    else if (m_wait == STARVE_MAX) m_stall = 1'b1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pipe_valid = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.ls_valid   = 1'b0; bus.ls_addr   = '0; bus.ls_data   = '0;
    bus.chk_addr1  = '0;   bus.chk_addr2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_wr: got %0b expected 0", bus.rf_wr); end
    checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.ls_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ls_ready: got %0b expected 0", bus.ls_ready); end
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", bus.pipe_stall); end
    reset = 1'b0;
    #1;
    checks++; if (bus.ls_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ls_ready: got %0b expected 1", bus.ls_ready); end
    // Queue two entries behind a busy pipeline, then reset mid-cycle.
    bus.pipe_valid = 1'b1; bus.pipe_addr = 5'd10; bus.pipe_data = 32'h10;
    bus.ls_valid = 1'b1; bus.ls_addr = 5'd7; bus.ls_data = 32'h1;
    tick();
    bus.ls_addr = 5'd8; bus.ls_data = 32'h2;
    tick();
    checks++; if (int'(bus.fifo_count) !== 2) begin errors++; $display("[TB] FAIL queued_count: got %0d expected 2", bus.fifo_count); end
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rf_wr: got %0b expected 0", bus.rf_wr); end
    checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.ls_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ls_ready: got %0b expected 0", bus.ls_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.ls_ready !== 1'b1) begin errors++; $display("[TB] FAIL rerelease_ls_ready: got %0b expected 1", bus.ls_ready); end
    tick();
    checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL no_partial_write: got %0b expected 0", bus.rf_wr); end
  endtask

  task automatic test_pipe_only();
    bus.pipe_valid = 1'b1; bus.pipe_addr = 5'd5; bus.pipe_data = 32'h1234;
    tick();
    checks++; if (bus.rf_wr !== 1'b1) begin errors++; $display("[TB] FAIL pipe_wr: got %0b expected 1", bus.rf_wr); end
    checks++; if (bus.rf_addr !== 5'd5) begin errors++; $display("[TB] FAIL pipe_addr: got %0d expected 5", bus.rf_addr); end
    checks++; if (bus.rf_data !== 32'h1234) begin errors++; $display("[TB] FAIL pipe_data: got %0h expected 1234", bus.rf_data); end
    bus.pipe_addr = 5'd0; bus.pipe_data = 32'hDEAD;
    tick();
    checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL pipe_r0_wr: got %0b expected 0", bus.rf_wr); end
    idle_inputs();
  endtask

  task automatic test_queue_drain();
    bus.pipe_valid = 1'b1; bus.pipe_addr = 5'd20; bus.pipe_data = 32'h20;
    bus.ls_valid = 1'b1; bus.ls_addr = 5'd7; bus.ls_data = 32'hAA;
    tick();
    bus.ls_addr = 5'd8; bus.ls_data = 32'hBB;
    tick();
    idle_inputs();
    bus.chk_addr1 = 5'd7; bus.chk_addr2 = 5'd8;
    #1;
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("[TB] FAIL pend_7: got %0b expected 1", bus.pend1); end
    checks++; if (bus.pend2 !== 1'b1) begin errors++; $display("[TB] FAIL pend_8: got %0b expected 1", bus.pend2); end
    tick();
    checks++; if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd7 || bus.rf_data !== 32'hAA) begin errors++; $display("[TB] FAIL drain_first: got wr=%0b addr=%0d data=%0h expected wr=1 addr=7 data=aa", bus.rf_wr, bus.rf_addr, bus.rf_data); end
    tick();
    checks++; if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd8 || bus.rf_data !== 32'hBB) begin errors++; $display("[TB] FAIL drain_second: got wr=%0b addr=%0d data=%0h expected wr=1 addr=8 data=bb", bus.rf_wr, bus.rf_addr, bus.rf_data); end
    checks++; if (bus.pend1 !== 1'b0 || bus.fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL drained: got pend1=%0b count=%0d expected 0 0", bus.pend1, bus.fifo_count); end
    idle_inputs();
  endtask

  task automatic test_kill();
    bus.pipe_valid = 1'b1; bus.pipe_addr = 5'd21; bus.pipe_data = 32'h21;
    bus.ls_valid = 1'b1; bus.ls_addr = 5'd9; bus.ls_data = 32'h1;
    tick();
    bus.ls_valid = 1'b0; bus.pipe_addr = 5'd9; bus.pipe_data = 32'h2;
    bus.chk_addr1 = 5'd9;
    tick();
    checks++; if (bus.rf_addr !== 5'd9 || bus.rf_data !== 32'h2) begin errors++; $display("[TB] FAIL kill_pipe_write: got addr=%0d data=%0h expected 9 2", bus.rf_addr, bus.rf_data); end
    checks++; if (bus.pend1 !== 1'b0) begin errors++; $display("[TB] FAIL kill_pend: got %0b expected 0", bus.pend1); end
    bus.pipe_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("[TB] FAIL killed_issued: got wr=%0b data=%0h expected no write", bus.rf_wr, bus.rf_data); end
    end
    checks++; if (bus.fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL kill_count: got %0d expected 0", bus.fifo_count); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int cycles;
    bus.pipe_valid = 1'b1; bus.pipe_addr = 5'd22; bus.pipe_data = 32'h22;
    bus.ls_valid = 1'b1; bus.ls_addr = 5'd11; bus.ls_data = 32'h77;
    tick();
    bus.ls_valid = 1'b0;
    cycles = 0;
    while (!bus.pipe_stall && cycles < 3 * STARVE_MAX) begin
      tick();
      cycles++;
    end
    checks++; if (bus.pipe_stall !== 1'b1 || cycles != STARVE_MAX) begin errors++; $display("[TB] FAIL stall_timing: got stall=%0b after %0d cycles expected 1 after %0d", bus.pipe_stall, cycles, STARVE_MAX); end
    tick();
    checks++; if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd11 || bus.rf_data !== 32'h77) begin errors++; $display("[TB] FAIL starved_issue: got wr=%0b addr=%0d data=%0h expected 1 11 77", bus.rf_wr, bus.rf_addr, bus.rf_data); end
    checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_drop: got %0b expected 0", bus.pipe_stall); end
    tick();
    checks++; if (bus.rf_addr !== 5'd22) begin errors++; $display("[TB] FAIL pipe_resume: got %0d expected 22", bus.rf_addr); end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [4:0] got[$];
    bit         acc;
    bus.pipe_valid = 1'b1; bus.pipe_addr = 5'd23; bus.pipe_data = 32'h23;
    bus.ls_valid = 1'b1; bus.ls_addr = 5'd12; bus.ls_data = 32'hC;
    tick();
    bus.ls_addr = 5'd13; bus.ls_data = 32'hD;
    tick();
    bus.ls_addr = 5'd14; bus.ls_data = 32'hE;
    checks++; if (bus.ls_ready !== 1'b0 || int'(bus.fifo_count) !== DEPTH) begin errors++; $display("[TB] FAIL full_state: got ready=%0b count=%0d expected 0 %0d", bus.ls_ready, bus.fifo_count, DEPTH); end
    bus.pipe_valid = 1'b0;
    for (int i = 0; i < 20 && got.size() < 3; i++) begin
      acc = bus.ls_valid && bus.ls_ready;
      tick();
      if (acc) bus.ls_valid = 1'b0;
      if (bus.rf_wr) got.push_back(bus.rf_addr);
    end
    checks++; if (got.size() != 3) begin errors++; $display("[TB] FAIL full_drain_len: got %0d writes expected 3", got.size()); end
    else if (got[0] !== 5'd12 || got[1] !== 5'd13 || got[2] !== 5'd14) begin errors++; $display("[TB] FAIL full_drain_order: got %0d,%0d,%0d expected 12,13,14", got[0], got[1], got[2]); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    int lat;
    int exp_lat;
    bit pend_seen;
`ifdef WB_LS_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    tick();
    bus.ls_valid = 1'b1; bus.ls_addr = 5'd3; bus.ls_data = 32'h55;
    bus.chk_addr1 = 5'd3;
    tick();
    bus.ls_valid = 1'b0;
    lat = 1;
    pend_seen = bus.pend1;
    while (!bus.rf_wr && lat < 6) begin
      tick();
      lat++;
    end
    checks++; if (lat != exp_lat || bus.rf_addr !== 5'd3 || bus.rf_data !== 32'h55) begin errors++; $display("[TB] FAIL bypass_latency: got lat=%0d addr=%0d data=%0h expected lat=%0d addr=3 data=55", lat, bus.rf_addr, bus.rf_data, exp_lat); end
    checks++; if (pend_seen !== (exp_lat == 2)) begin errors++; $display("[TB] FAIL bypass_pend: got %0b expected %0b", pend_seen, exp_lat == 2); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bus.pipe_valid = ($urandom_range(0, 3) != 0);
      bus.pipe_addr  = 5'($urandom_range(0, 3));
      bus.pipe_data  = $urandom;
      bus.ls_valid   = $urandom_range(0, 1) == 1;
      bus.ls_addr    = 5'($urandom_range(0, 3));
      bus.ls_data    = $urandom;
      bus.chk_addr1  = 5'($urandom_range(0, 3));
      bus.chk_addr2  = 5'($urandom_range(0, 3));
      tick();
      checks++; if (bus.rf_wr !== m_wr) begin errors++; $display("[TB] FAIL rnd_wr cycle %0d: got %0b expected %0b", n, bus.rf_wr, m_wr); end
      if (m_wr) begin
        checks++; if (bus.rf_addr !== m_addr || bus.rf_data !== m_data) begin errors++; $display("[TB] FAIL rnd_write cycle %0d: got %0d/%0h expected %0d/%0h", n, bus.rf_addr, bus.rf_data, m_addr, m_data); end
      end
      checks++; if (bus.pipe_stall !== m_stall) begin errors++; $display("[TB] FAIL rnd_stall cycle %0d: got %0b expected %0b", n, bus.pipe_stall, m_stall); end
      checks++; if (int'(bus.fifo_count) !== mq.size() || bus.ls_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_occupancy cycle %0d: got count=%0d ready=%0b expected %0d", n, bus.fifo_count, bus.ls_ready, mq.size()); end
      checks++; if (bus.pend1 !== m_pend(bus.chk_addr1) || bus.pend2 !== m_pend(bus.chk_addr2)) begin errors++; $display("[TB] FAIL rnd_pend cycle %0d: got %0b%0b expected %0b%0b", n, bus.pend1, bus.pend2, m_pend(bus.chk_addr1), m_pend(bus.chk_addr2)); end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    $display("[TB] wb_arbiter bench start");
    test_reset();
    test_pipe_only();
    test_queue_drain();
    test_kill();
    test_starvation();
    test_full();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
